// File: rtl/cpfifo.sv
// rtl/cpfifo.sv - width-converting show-ahead FIFO: wide words in, narrow slices out.
module cpfifo #(
    parameter int DATA_W    = 64,
    parameter int RATIO     = 4,
    parameter int DEPTH     = 128,
    parameter int LSB_FIRST = 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            wr,
    input  logic [DATA_W-1:0]               data,
    output logic                            full,
    input  logic                            rd,
    output logic [DATA_W/RATIO-1:0]         q,
    output logic                            empty,
    output logic [$clog2(DEPTH*RATIO):0]    level,
    output logic                            ovf,
    output logic                            unf
);

    localparam int NARROW_W = DATA_W / RATIO;
    localparam int SUB_W    = $clog2(RATIO);
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int SLOT_W   = PTR_W + 1;
    localparam int LVL_W    = $clog2(DEPTH*RATIO) + 1;

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]    r_wptr;
    logic [PTR_W-1:0]    r_rptr;
    logic [SUB_W-1:0]    r_sub;
    logic [LVL_W-1:0]    r_level;
    logic [SLOT_W-1:0]   r_slots;
    logic                r_ovf;
    logic                r_unf;

    logic                w_empty;
    logic                w_full;
    logic                w_last;
    logic                w_rd_ok;
    logic                w_pop_frees;
    logic                w_wr_ok;
    logic [SUB_W-1:0]    w_slice;
    logic [DATA_W-1:0]   w_head;
    logic [NARROW_W-1:0] w_q;

    assign w_empty     = (r_level == '0);
    // A partially consumed head slot still counts as occupied until its last slice pops.
    assign w_full      = (r_slots == SLOT_W'(DEPTH));
    assign w_last      = (r_sub == SUB_W'(RATIO-1));
    assign w_rd_ok     = rd && !w_empty;
    assign w_pop_frees = w_rd_ok && w_last;
    assign w_wr_ok     = wr && (!w_full || w_pop_frees);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_sub   <= '0;
            r_level <= '0;
            r_slots <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (clear) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_sub   <= '0;
            r_level <= '0;
            r_slots <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            if (w_wr_ok)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd_ok) begin
                r_sub <= r_sub + 1'b1;
                if (w_last)
                    r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + (w_wr_ok ? LVL_W'(RATIO) : '0) - LVL_W'(w_rd_ok);
            r_slots <= r_slots + SLOT_W'(w_wr_ok) - SLOT_W'(w_pop_frees);
            if (wr && !w_wr_ok)
                r_ovf <= 1'b1;
            if (rd && !w_rd_ok)
                r_unf <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!clear && w_wr_ok)
            r_mem[r_wptr] <= data;
    end

    assign w_head  = r_mem[r_rptr];
    assign w_slice = (LSB_FIRST != 0) ? r_sub : (SUB_W'(RATIO-1) - r_sub);

    always_comb begin
        w_q = '0;
        if (!w_empty) begin
            for (int k = 0; k < RATIO; k++) begin
                if (w_slice == SUB_W'(k))
                    w_q = w_head[k*NARROW_W +: NARROW_W];
            end
        end
    end

    assign q     = w_q;
    assign full  = w_full;
    assign empty = w_empty;
    assign level = r_level;
    assign ovf   = r_ovf;
    assign unf   = r_unf;

endmodule

// File: tb/tb_cpfifo.sv
// tb/tb_cpfifo.sv - scoreboard bench for cpfifo (64->16, depth 4).
module tb_cpfifo;

    logic        clock;
    logic        reset_n;
    logic        clear;
    logic        wr;
    logic [63:0] data;
    logic        full;
    logic        rd;
    logic [15:0] q;
    logic        empty;
    logic [4:0]  level;
    logic        ovf;
    logic        unf;

    logic        m_wr;
    logic [63:0] m_data;
    logic        m_full;
    logic        m_rd;
    logic [15:0] m_q;
    logic        m_empty;
    logic [4:0]  m_level;
    logic        m_ovf;
    logic        m_unf;

    int n_checks = 0;
    int n_pass   = 0;
    logic [15:0] exp_q[$];
    logic [63:0] words[4];

    cpfifo #(.DATA_W(64), .RATIO(4), .DEPTH(4), .LSB_FIRST(1)) dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .wr(wr), .data(data),
        .full(full), .rd(rd), .q(q), .empty(empty), .level(level), .ovf(ovf), .unf(unf)
    );

    cpfifo #(.DATA_W(64), .RATIO(4), .DEPTH(4), .LSB_FIRST(0)) dut_msb (
        .clock(clock), .reset_n(reset_n), .clear(clear), .wr(m_wr), .data(m_data),
        .full(m_full), .rd(m_rd), .q(m_q), .empty(m_empty), .level(m_level), .ovf(m_ovf), .unf(m_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    // Monitor: every accepted pop on the main instance must match the scoreboard head.
    always @(negedge clock) begin
        if (reset_n && !clear && rd && !empty) begin
            if (exp_q.size() == 0) begin
                check("sb_underrun", {48'h0, q}, 64'hDEAD);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                check("sb_q", {48'h0, q}, {48'h0, e});
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push_word(input logic [63:0] w, input int first, input int last);
        for (int k = first; k <= last; k++)
            exp_q.push_back(w[k*16 +: 16]);
    endtask

    task automatic write_word(input logic [63:0] w);
        wr = 1'b1; data = w; cyc(); wr = 1'b0;
    endtask

    task automatic pop_n(input int n);
        rd = 1'b1;
        repeat (n) cyc();
        rd = 1'b0;
    endtask

    task automatic fill_to_ten();
        for (int i = 0; i < 4; i++) write_word(words[i]);
        write_word(64'hFFFF_FFFF_FFFF_FFFF);
        push_word(words[0], 0, 3);
        push_word(words[1], 0, 1);
        pop_n(6);
        check("t6_level10", level, 10);
        check("t6_ovf_set", ovf, 1);
    endtask

    initial begin
        words[0] = 64'h0A03_0A02_0A01_0A00;
        words[1] = 64'h0B03_0B02_0B01_0B00;
        words[2] = 64'h0C03_0C02_0C01_0C00;
        words[3] = 64'h0D03_0D02_0D01_0D00;
        reset_n = 1'b0; clear = 1'b0; wr = 1'b0; rd = 1'b0; data = '0;
        m_wr = 1'b0; m_rd = 1'b0; m_data = '0;
        #12;
        check("rst_level", level, 0);
        check("rst_empty", empty, 1);
        check("rst_full",  full, 0);
        check("rst_ovf",   ovf, 0);
        check("rst_unf",   unf, 0);
        check("rst_q",     q, 0);
        reset_n = 1'b1;
        cyc();

        // 1: single word, four pops
        write_word(64'h4444_3333_2222_1111);
        check("t1_level4", level, 4);
        push_word(64'h4444_3333_2222_1111, 0, 3);
        rd = 1'b1;
        cyc(); check("t1_level3", level, 3);
        cyc(); check("t1_level2", level, 2);
        cyc(); check("t1_level1", level, 1);
        cyc(); check("t1_level0", level, 0);
        rd = 1'b0;
        check("t1_empty", empty, 1);
        check("t1_q0", q, 0);

        // 2: fill, overflow, drain
        for (int i = 0; i < 4; i++) write_word(words[i]);
        check("t2_full", full, 1);
        check("t2_level16", level, 16);
        check("t2_ovf_pre", ovf, 0);
        write_word(64'h5555_5555_5555_5555);
        check("t2_ovf", ovf, 1);
        check("t2_level_hold", level, 16);
        for (int i = 0; i < 4; i++) push_word(words[i], 0, 3);
        pop_n(16);
        check("t2_empty", empty, 1);

        // 3: pop through head slot while writing into the freed slot
        clear = 1'b1; cyc(); clear = 1'b0;
        check("t3_ovf_clr", ovf, 0);
        for (int i = 0; i < 4; i++) write_word(words[i]);
        push_word(words[0], 0, 3);
        pop_n(3);
        check("t3_level13", level, 13);
        check("t3_full13", full, 1);
        rd = 1'b1; wr = 1'b1; data = 64'h0E03_0E02_0E01_0E00;
        cyc();
        rd = 1'b0; wr = 1'b0;
        check("t3_level16", level, 16);
        check("t3_full", full, 1);
        check("t3_ovf", ovf, 0);
        check("t3_head", q, 16'h0B00);
        push_word(words[1], 0, 3);
        push_word(words[2], 0, 3);
        push_word(words[3], 0, 3);
        push_word(64'h0E03_0E02_0E01_0E00, 0, 3);
        pop_n(16);
        check("t3_empty", empty, 1);

        // 4: underflow, then rd+wr on empty
        rd = 1'b1; cyc(); rd = 1'b0;
        check("t4_unf", unf, 1);
        check("t4_level0", level, 0);
        rd = 1'b1; wr = 1'b1; data = 64'hDDDD_CCCC_BBBB_AAAA;
        cyc();
        rd = 1'b0; wr = 1'b0;
        check("t4_level4", level, 4);
        check("t4_q", q, 16'hAAAA);
        push_word(64'hDDDD_CCCC_BBBB_AAAA, 0, 3);
        pop_n(4);
        check("t4_empty", empty, 1);

        // 5: most-significant slice first
        m_wr = 1'b1; m_data = 64'h4444_3333_2222_1111; cyc(); m_wr = 1'b0;
        check("t5_q0", m_q, 16'h4444);
        m_rd = 1'b1;
        cyc(); check("t5_q1", m_q, 16'h3333);
        cyc(); check("t5_q2", m_q, 16'h2222);
        cyc(); check("t5_q3", m_q, 16'h1111);
        cyc(); m_rd = 1'b0;
        check("t5_empty", m_empty, 1);

        // 6a: asynchronous reset mid-stream
        clear = 1'b1; cyc(); clear = 1'b0;
        fill_to_ten();
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_level", level, 0);
        check("t6_rst_empty", empty, 1);
        check("t6_rst_full",  full, 0);
        check("t6_rst_ovf",   ovf, 0);
        check("t6_rst_q",     q, 0);
        reset_n = 1'b1;
        cyc();

        // 6b: synchronous clear wins over a concurrent write
        fill_to_ten();
        clear = 1'b1; wr = 1'b1; data = 64'h9999_8888_7777_6666;
        cyc();
        clear = 1'b0; wr = 1'b0;
        check("t6_clr_level", level, 0);
        check("t6_clr_empty", empty, 1);
        check("t6_clr_full",  full, 0);
        check("t6_clr_ovf",   ovf, 0);
        check("t6_clr_q",     q, 0);
        cyc();
        check("t6_clr_nowrite", level, 0);

        check("sb_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
